// File: rtl/cpu_pkg.sv
// Shared CPU definitions: packed control-word layout used by the ID/EX,
// EX/MEM and control-unit slices, plus the WB bypass hit test.
//   CTRL_W             : width of the packed control word
//   CTRL_*             : bit positions inside the control word
//   BUBBLE_CTRL        : control word of an inserted bubble (no side effects)
//   wb_hits()          : true when a WB write targets a given source register
package cpu_pkg;

   localparam int unsigned CTRL_W          = 10;
   localparam int unsigned CTRL_REG_W_EN   = 9;
   localparam int unsigned CTRL_MEM_READ   = 8;
   localparam int unsigned CTRL_MEM_WRITE  = 7;
   localparam int unsigned CTRL_MEM_TO_REG = 6;
   localparam int unsigned CTRL_ALU_SRC    = 5;
   localparam int unsigned CTRL_ALU_OP_MSB = 4;
   localparam int unsigned CTRL_ALU_OP_LSB = 0;

   typedef logic [CTRL_W-1:0] ctrl_t;
   typedef logic [4:0]        reg_idx_t;

   localparam ctrl_t BUBBLE_CTRL = '0;

   // Register $0 is hard-wired zero, so a write to it is never bypassed.
   function automatic logic wb_hits(input logic     w_en,
                                    input reg_idx_t w_dest,
                                    input reg_idx_t src);
      return w_en && (w_dest != '0) && (w_dest == src);
   endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector.
//   id_valid_i, id_reg_src1_i, id_reg_src2_i, id_uses_rs_i, id_uses_rt_i :
//       instruction currently in ID and which source registers it reads
//   ex_valid_i, ex_mem_read_i, ex_reg_dest_i :
//       instruction currently in EX (a load if ex_mem_read_i)
//   lu_o : ID needs a value that the load in EX has not fetched yet
module load_use_detect
   import cpu_pkg::*;
(
   input  logic     id_valid_i,
   input  reg_idx_t id_reg_src1_i,
   input  reg_idx_t id_reg_src2_i,
   input  logic     id_uses_rs_i,
   input  logic     id_uses_rt_i,
   input  logic     ex_valid_i,
   input  logic     ex_mem_read_i,
   input  reg_idx_t ex_reg_dest_i,
   output logic     lu_o
);

   logic rs_dep;
   logic rt_dep;

   always_comb begin
      rs_dep = id_uses_rs_i && (id_reg_src1_i == ex_reg_dest_i);
      rt_dep = id_uses_rt_i && (id_reg_src2_i == ex_reg_dest_i);
      // A load into $0 produces nothing, so it never creates a hazard.
      lu_o   = id_valid_i && ex_valid_i && ex_mem_read_i &&
               (ex_reg_dest_i != '0) && (rs_dep || rt_dep);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch-flush bubbles and
// same-cycle WB bypass into the captured register operands.
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_*                  : decoded instruction in ID (operands, indices, control)
//   flush_ex              : taken branch/jump resolved in EX; squash ID
//   wb_reg_w_en/dest/value: regfile write happening this cycle
//   stall_if_id           : hold PC and IF/ID (load-use hazard, not flushed)
//   ex_*                  : registered instruction presented to EX
//   stall_cnt             : saturating count of load-use stall cycles
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_rs_value,
   input  logic [DATA_W-1:0] id_rt_value,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [4:0]        id_reg_src1,
   input  logic [4:0]        id_reg_src2,
   input  logic [4:0]        id_reg_dest,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [9:0]        id_ctrl,
   input  logic              flush_ex,
   input  logic              wb_reg_w_en,
   input  logic [4:0]        wb_reg_dest,
   input  logic [DATA_W-1:0] wb_value,
   output logic              stall_if_id,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_rs_value,
   output logic [DATA_W-1:0] ex_rt_value,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_reg_src1,
   output logic [4:0]        ex_reg_src2,
   output logic [4:0]        ex_reg_dest,
   output logic [9:0]        ex_ctrl,
   output logic              ex_reg_w_en,
   output logic              ex_mem_read,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              lu;
   logic              bubble;

   logic              valid_q,  valid_d;
   logic [DATA_W-1:0] pc_q,     pc_d;
   logic [DATA_W-1:0] rs_q,     rs_d;
   logic [DATA_W-1:0] rt_q,     rt_d;
   logic [DATA_W-1:0] imm_q,    imm_d;
   reg_idx_t          src1_q,   src1_d;
   reg_idx_t          src2_q,   src2_d;
   reg_idx_t          dest_q,   dest_d;
   ctrl_t             ctrl_q,   ctrl_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;

   load_use_detect u_lud (
      .id_valid_i    (id_valid),
      .id_reg_src1_i (id_reg_src1),
      .id_reg_src2_i (id_reg_src2),
      .id_uses_rs_i  (id_uses_rs),
      .id_uses_rt_i  (id_uses_rt),
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q[CTRL_MEM_READ]),
      .ex_reg_dest_i (dest_q),
      .lu_o          (lu)
   );

   // Flush dominates: a squashed ID instruction must not freeze the front end.
   assign stall_if_id = lu && !flush_ex;

   // Flush, stall and an empty ID slot all collapse to the same bubble.
   assign bubble = flush_ex || lu || !id_valid;

   always_comb begin
      valid_d = 1'b0;
      pc_d    = '0;
      rs_d    = '0;
      rt_d    = '0;
      imm_d   = '0;
      src1_d  = '0;
      src2_d  = '0;
      dest_d  = '0;
      ctrl_d  = BUBBLE_CTRL;
      cnt_d   = cnt_q;

      if (!bubble) begin
         valid_d = 1'b1;
         pc_d    = id_pc;
         rs_d    = wb_hits(wb_reg_w_en, wb_reg_dest, id_reg_src1) ? wb_value : id_rs_value;
         rt_d    = wb_hits(wb_reg_w_en, wb_reg_dest, id_reg_src2) ? wb_value : id_rt_value;
         imm_d   = id_imm;
         src1_d  = id_reg_src1;
         src2_d  = id_reg_src2;
         dest_d  = id_reg_dest;
         ctrl_d  = id_ctrl;
      end

      // Only real stalls count; a flushed hazard is not a stall.
      if (stall_if_id && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         imm_q   <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
         dest_q  <= '0;
         ctrl_q  <= BUBBLE_CTRL;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         imm_q   <= imm_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         dest_q  <= dest_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_pc       = pc_q;
   assign ex_rs_value = rs_q;
   assign ex_rt_value = rt_q;
   assign ex_imm      = imm_q;
   assign ex_reg_src1 = src1_q;
   assign ex_reg_src2 = src2_q;
   assign ex_reg_dest = dest_q;
   assign ex_ctrl     = ctrl_q;
   assign ex_reg_w_en = ctrl_q[CTRL_REG_W_EN];
   assign ex_mem_read = ctrl_q[CTRL_MEM_READ];
   assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   localparam int unsigned DW      = 32;
   localparam int unsigned CW      = 6;
   localparam int unsigned CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          id_valid;
   logic [DW-1:0] id_pc, id_rs_value, id_rt_value, id_imm;
   logic [4:0]    id_reg_src1, id_reg_src2, id_reg_dest;
   logic          id_uses_rs, id_uses_rt;
   logic [9:0]    id_ctrl;
   logic          flush_ex;
   logic          wb_reg_w_en;
   logic [4:0]    wb_reg_dest;
   logic [DW-1:0] wb_value;
   logic          stall_if_id, ex_valid;
   logic [DW-1:0] ex_pc, ex_rs_value, ex_rt_value, ex_imm;
   logic [4:0]    ex_reg_src1, ex_reg_src2, ex_reg_dest;
   logic [9:0]    ex_ctrl;
   logic          ex_reg_w_en, ex_mem_read;
   logic [CW-1:0] stall_cnt;

   id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs_value(id_rs_value),
      .id_rt_value(id_rt_value), .id_imm(id_imm),
      .id_reg_src1(id_reg_src1), .id_reg_src2(id_reg_src2), .id_reg_dest(id_reg_dest),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl),
      .flush_ex(flush_ex),
      .wb_reg_w_en(wb_reg_w_en), .wb_reg_dest(wb_reg_dest), .wb_value(wb_value),
      .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs_value(ex_rs_value), .ex_rt_value(ex_rt_value), .ex_imm(ex_imm),
      .ex_reg_src1(ex_reg_src1), .ex_reg_src2(ex_reg_src2), .ex_reg_dest(ex_reg_dest),
      .ex_ctrl(ex_ctrl), .ex_reg_w_en(ex_reg_w_en), .ex_mem_read(ex_mem_read),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference view of what EX should hold, kept as a plain record.
   typedef struct {
      bit            valid;
      logic [DW-1:0] pc, rs, rt, imm;
      logic [4:0]    s1, s2, d;
      logic [9:0]    ctrl;
   } ex_t;

   ex_t         m;
   int unsigned m_cnt;
   int unsigned tests;
   int unsigned fails;

   localparam logic [9:0] C_LW  = 10'b11_0000_0000;  // reg_w_en + mem_read
   localparam logic [9:0] C_ADD = 10'b10_0000_0010;  // reg_w_en, alu op

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m     = '{valid: 1'b0, pc: '0, rs: '0, rt: '0, imm: '0, s1: '0, s2: '0, d: '0, ctrl: '0};
      m_cnt = 0;
   endtask

   task automatic check_ex();
      chk("ex_valid",    ex_valid,    m.valid);
      chk("ex_pc",       ex_pc,       m.pc);
      chk("ex_rs_value", ex_rs_value, m.rs);
      chk("ex_rt_value", ex_rt_value, m.rt);
      chk("ex_imm",      ex_imm,      m.imm);
      chk("ex_reg_src1", ex_reg_src1, m.s1);
      chk("ex_reg_src2", ex_reg_src2, m.s2);
      chk("ex_reg_dest", ex_reg_dest, m.d);
      chk("ex_ctrl",     ex_ctrl,     m.ctrl);
      chk("ex_reg_w_en", ex_reg_w_en, m.ctrl[9]);
      chk("ex_mem_read", ex_mem_read, m.ctrl[8]);
      chk("stall_cnt",   stall_cnt,   m_cnt);
   endtask

   // Checks the combinational stall for the current inputs, advances the
   // reference by one edge, clocks the DUT and compares the whole EX view.
   task automatic tick();
      bit   load_in_ex, needs_it, lu;
      ex_t  n;
      #1;
      load_in_ex = m.valid && m.ctrl[8] && (m.d != 0);
      needs_it   = (id_uses_rs && id_reg_src1 == m.d) || (id_uses_rt && id_reg_src2 == m.d);
      lu         = id_valid && load_in_ex && needs_it;
      chk("stall_if_id", stall_if_id, lu && !flush_ex);

      n = '{valid: 1'b0, pc: '0, rs: '0, rt: '0, imm: '0, s1: '0, s2: '0, d: '0, ctrl: '0};
      if (flush_ex) begin
         // bubble only
      end else if (lu) begin
         if (m_cnt < CNT_MAX) m_cnt++;
      end else if (id_valid) begin
         n.valid = 1'b1;
         n.pc    = id_pc;
         n.imm   = id_imm;
         n.s1    = id_reg_src1;
         n.s2    = id_reg_src2;
         n.d     = id_reg_dest;
         n.ctrl  = id_ctrl;
         n.rs    = (wb_reg_w_en && wb_reg_dest != 0 && wb_reg_dest == id_reg_src1) ? wb_value : id_rs_value;
         n.rt    = (wb_reg_w_en && wb_reg_dest != 0 && wb_reg_dest == id_reg_src2) ? wb_value : id_rt_value;
      end
      m = n;
      @(posedge clk);
      #1;
      check_ex();
   endtask

   task automatic set_id(input logic v, input logic [DW-1:0] pc,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic urs, input logic urt, input logic [9:0] ctrl);
      id_valid    = v;
      id_pc       = pc;
      id_rs_value = pc ^ 32'h1111_0000;
      id_rt_value = pc ^ 32'h2222_0000;
      id_imm      = pc + 32'd4;
      id_reg_src1 = s1;
      id_reg_src2 = s2;
      id_reg_dest = d;
      id_uses_rs  = urs;
      id_uses_rt  = urt;
      id_ctrl     = ctrl;
      flush_ex    = 1'b0;
      wb_reg_w_en = 1'b0;
      wb_reg_dest = '0;
      wb_value    = '0;
   endtask

   task automatic randomize_inputs();
      id_valid    = ($urandom_range(0, 9) < 8);
      id_pc       = $urandom;
      id_rs_value = $urandom;
      id_rt_value = $urandom;
      id_imm      = $urandom;
      id_reg_src1 = 5'($urandom_range(0, 3));
      id_reg_src2 = 5'($urandom_range(0, 3));
      id_reg_dest = 5'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      id_ctrl     = 10'($urandom);
      flush_ex    = ($urandom_range(0, 9) == 0);
      wb_reg_w_en = 1'($urandom_range(0, 1));
      wb_reg_dest = 5'($urandom_range(0, 3));
      wb_value    = $urandom;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      model_reset();
      set_id(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
      rst_n = 1'b0;
      #12;
      check_ex();
      chk("rst_stall", stall_if_id, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Load-use: lw $2 then add $3,$2,$4 costs exactly one bubble.
      set_id(1'b1, 32'h100, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, C_LW);
      tick();
      set_id(1'b1, 32'h104, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1, C_ADD);
      #1 chk("lu_stall", stall_if_id, 1'b1);
      tick();
      chk("lu_bubble_valid", ex_valid, 1'b0);
      chk("lu_bubble_ctrl",  ex_ctrl, 10'd0);
      chk("lu_cnt_one",      stall_cnt, 1);
      tick();
      chk("lu_add_valid", ex_valid, 1'b1);
      chk("lu_add_src1",  ex_reg_src1, 5'd2);

      // rt matches the load but is not read: no stall.
      set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, C_LW);
      tick();
      set_id(1'b1, 32'h204, 5'd4, 5'd2, 5'd3, 1'b1, 1'b0, C_ADD);
      #1 chk("nouse_stall", stall_if_id, 1'b0);
      tick();
      chk("nouse_valid", ex_valid, 1'b1);
      chk("nouse_pc",    ex_pc, 32'h204);

      // Hazard while flushing: no stall, bubble, counter unchanged.
      set_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, C_LW);
      tick();
      set_id(1'b1, 32'h304, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1, C_ADD);
      flush_ex = 1'b1;
      #1 chk("flush_stall", stall_if_id, 1'b0);
      tick();
      chk("flush_valid", ex_valid, 1'b0);
      chk("flush_cnt",   stall_cnt, 1);

      // WB bypass into rs, and $0 never bypassed.
      set_id(1'b1, 32'h400, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, C_ADD);
      id_rs_value = 32'h1;
      wb_reg_w_en = 1'b1; wb_reg_dest = 5'd5; wb_value = 32'hDEADBEEF;
      tick();
      chk("byp_rs", ex_rs_value, 32'hDEADBEEF);
      set_id(1'b1, 32'h404, 5'd0, 5'd6, 5'd7, 1'b1, 1'b1, C_ADD);
      id_rs_value = 32'h1;
      wb_reg_w_en = 1'b1; wb_reg_dest = 5'd0; wb_value = 32'hDEADBEEF;
      tick();
      chk("byp_r0", ex_rs_value, 32'h1);

      // Randomized traffic against the reference.
      for (int i = 0; i < 300; i++) begin
         randomize_inputs();
         tick();
      end

      // Asynchronous reset between edges clears everything at once.
      randomize_inputs();
      id_valid = 1'b1; flush_ex = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_ex();
      chk("midrst_stall", stall_if_id, 1'b0);
      #1 rst_n = 1'b1;
      set_id(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
      tick();

      // Saturation: one stall per load/use pair, more pairs than the counter holds.
      for (int i = 0; i < int'(CNT_MAX) + 4; i++) begin
         set_id(1'b1, 32'h800, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, C_LW);
         tick();
         set_id(1'b1, 32'h804, 5'd0, 5'd9, 5'd3, 1'b0, 1'b1, C_ADD);
         tick();
      end
      chk("cnt_saturated", stall_cnt, CNT_MAX);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
